// File: rtl/pulse_to_toggle_hs.sv
// Per-channel pulse-to-toggle CDC encoder: 0-cycle issue latency from IDLE, next toggle only after the ack echo matches.
// Back-pressure: pulses arriving while busy queue in a CNT_W counter; an event is dropped (sticky overflow) only when that counter is full.
module pulse_to_toggle_hs #(
  parameter int NCH         = 1,
  parameter int ACTIVE_LOW  = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] pulse,
  input  logic [NCH-1:0] ack_toggle,
  input  logic           clr_overflow,
  output logic [NCH-1:0] toggle,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] overflow
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state;
    logic [CNT_W-1:0]       pending;
    logic                   toggle_q;
    logic                   overflow_q;
    logic                   det;
    logic                   match;
    logic                   have_evt;
    logic                   issue;
    logic                   drop;

    assign det      = (ACTIVE_LOW != 0) ? ~pulse[i] : pulse[i];
    assign match    = (sync_q[SYNC_STAGES-1] == toggle_q);
    assign have_evt = det | (pending != '0);
    // IDLE issues unconditionally; WAIT only once the echoed toggle has caught up
    assign issue    = have_evt & ((state == IDLE) | match);
    assign drop     = det & ~issue & (pending == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q     <= '0;
        state      <= IDLE;
        pending    <= '0;
        toggle_q   <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], ack_toggle[i]};

        if (issue) begin
          toggle_q <= ~toggle_q;
          state    <= WAIT;
          // a queued event is served first; a same-cycle det takes its slot
          if ((pending != '0) && !det) begin
            pending <= pending - 1'b1;
          end
        end else begin
          if ((state == WAIT) && match) begin
            state <= IDLE;
          end
          if (det && (pending != CNT_MAX)) begin
            pending <= pending + 1'b1;
          end
        end

        if (drop) begin
          overflow_q <= 1'b1;
        end else if (clr_overflow) begin
          overflow_q <= 1'b0;
        end
      end
    end

    assign toggle[i]   = toggle_q;
    assign overflow[i] = overflow_q;
    assign busy[i]     = (state == WAIT) | (pending != '0);
  end

endmodule

// File: tb/tb_pulse_to_toggle_hs.sv
// Bench for pulse_to_toggle_hs: instance A is active-high with a deep queue, instance B is active-low with a shallow queue.
// Every accepted event pushes its expected toggle value; the negedge monitor pops one per observed flip.
module tb_pulse_to_toggle_hs;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [1:0] pulse_a = 2'b00;
  logic [1:0] ack_a = 2'b00;
  logic [1:0] toggle_a, busy_a, ovf_a;
  logic [3:0] pulse_b = 4'hF;
  logic [3:0] ack_b = 4'h0;
  logic [3:0] toggle_b, busy_b, ovf_b;

  int n_checks = 0;
  int n_errors = 0;

  int q_a [2][$];
  int q_b [4][$];
  logic [1:0] exp_a = '0;
  logic [3:0] exp_b = '0;
  logic [1:0] last_a = '0;
  logic [3:0] last_b = '0;
  int flips_a [2];
  int flips_b [4];

  always #5 clk = ~clk;

  pulse_to_toggle_hs #(.NCH(2), .ACTIVE_LOW(0), .SYNC_STAGES(2), .CNT_W(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .pulse(pulse_a), .ack_toggle(ack_a),
    .clr_overflow(clr_ovf), .toggle(toggle_a), .busy(busy_a), .overflow(ovf_a)
  );

  pulse_to_toggle_hs #(.NCH(4), .ACTIVE_LOW(1), .SYNC_STAGES(2), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .pulse(pulse_b), .ack_toggle(ack_b),
    .clr_overflow(clr_ovf), .toggle(toggle_b), .busy(busy_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int inst, input int ch);
    if (inst == 0) begin
      exp_a[ch] = ~exp_a[ch];
      q_a[ch].push_back(int'(exp_a[ch]));
    end else begin
      exp_b[ch] = ~exp_b[ch];
      q_b[ch].push_back(int'(exp_b[ch]));
    end
  endtask

  // destination model: echo each toggle one cycle after it appears, until the channel is idle
  task automatic drain(input int inst, input int ch);
    for (int i = 0; i < 300; i++) begin
      step();
      if (inst == 0) begin
        if (toggle_a[ch] != ack_a[ch]) begin
          step();
          ack_a[ch] = toggle_a[ch];
        end else if (!busy_a[ch]) begin
          break;
        end
      end else begin
        if (toggle_b[ch] != ack_b[ch]) begin
          step();
          ack_b[ch] = toggle_b[ch];
        end else if (!busy_b[ch]) begin
          break;
        end
      end
    end
    check($sformatf("drain_idle_%0d_%0d", inst, ch),
          32'((inst == 0) ? busy_a[ch] : busy_b[ch]), 0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      last_a = toggle_a;
      last_b = toggle_b;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (toggle_a[c] !== last_a[c]) begin
          flips_a[c]++;
          check($sformatf("a%0d_flip_expected", c), 32'(q_a[c].size() > 0), 1);
          if (q_a[c].size() > 0) check($sformatf("a%0d_flip_val", c), 32'(toggle_a[c]), q_a[c].pop_front());
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (toggle_b[c] !== last_b[c]) begin
          flips_b[c]++;
          check($sformatf("b%0d_flip_expected", c), 32'(q_b[c].size() > 0), 1);
          if (q_b[c].size() > 0) check($sformatf("b%0d_flip_val", c), 32'(toggle_b[c]), q_b[c].pop_front());
        end
      end
      last_a = toggle_a;
      last_b = toggle_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f;
    for (int c = 0; c < 2; c++) flips_a[c] = 0;
    for (int c = 0; c < 4; c++) flips_b[c] = 0;

    // reset state
    #2;
    check("rst_toggle_a", 32'(toggle_a), 0);
    check("rst_busy_a",   32'(busy_a),   0);
    check("rst_ovf_a",    32'(ovf_a),    0);
    check("rst_toggle_b", 32'(toggle_b), 0);
    check("rst_busy_b",   32'(busy_b),   0);
    check("rst_ovf_b",    32'(ovf_b),    0);
    step();
    reset_n = 1'b1;
    repeat (3) step();

    // single event: zero-latency issue, busy clears three edges after the echo
    pulse_a[0] = 1'b1; accept(0, 0);
    step();
    pulse_a[0] = 1'b0;
    check("single_toggle", 32'(toggle_a[0]), 1);
    check("single_busy",   32'(busy_a[0]),   1);
    repeat (4) step();
    check("single_busy_hold", 32'(busy_a[0]), 1);
    ack_a[0] = 1'b1;
    step(); step();
    check("single_busy_sync", 32'(busy_a[0]), 1);
    step();
    check("single_busy_clear", 32'(busy_a[0]), 0);

    // burst of 5: one issued, four queued, then replayed one per match
    for (int k = 0; k < 5; k++) begin
      pulse_a[0] = 1'b1; accept(0, 0);
      step();
    end
    pulse_a[0] = 1'b0;
    check("burst_toggle", 32'(toggle_a[0]), 0);
    check("burst_busy",   32'(busy_a[0]),   1);
    repeat (5) step();
    check("burst_hold", 32'(toggle_a[0]), 0);
    f = flips_a[0];
    drain(0, 0);
    check("burst_replay_flips", 32'(flips_a[0] - f), 4);

    // issue and queue on the same edge: pending must stay at 2
    f = flips_a[1];
    for (int k = 0; k < 3; k++) begin
      pulse_a[1] = 1'b1; accept(0, 1);
      step();
    end
    pulse_a[1] = 1'b0;
    ack_a[1] = 1'b1;
    step(); step();
    pulse_a[1] = 1'b1; accept(0, 1);
    step();
    pulse_a[1] = 1'b0;
    check("simul_toggle", 32'(toggle_a[1]), 0);
    check("simul_busy",   32'(busy_a[1]),   1);
    drain(0, 1);
    check("simul_total_flips", 32'(flips_a[1] - f), 4);

    // overflow on the shallow active-low instance
    for (int k = 0; k < 5; k++) begin
      pulse_b[2] = 1'b0;
      if (k < 4) accept(1, 2);
      step();
      if (k == 3) check("ovf_before_full", 32'(ovf_b[2]), 0);
      if (k == 4) check("ovf_on_drop",     32'(ovf_b[2]), 1);
    end
    f = flips_b[2];
    clr_ovf = 1'b1;
    step();
    check("ovf_set_wins", 32'(ovf_b[2]), 1);
    pulse_b[2] = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf_b), 0);
    drain(1, 2);
    check("ovf_replay_flips", 32'(flips_b[2] - f), 3);

    // simultaneous active-low events on ch0 and ch3
    pulse_b = 4'b0110; accept(1, 0); accept(1, 3);
    step();
    pulse_b = 4'hF;
    check("multi_toggle", 32'(toggle_b), 32'h9);
    check("multi_busy",   32'(busy_b),   32'h9);
    drain(1, 3);
    check("multi_busy_ch0_only", 32'(busy_b), 32'h1);
    drain(1, 0);
    check("multi_busy_done", 32'(busy_b), 0);
    for (int c = 0; c < 2; c++) check($sformatf("a%0d_queue_empty", c), 32'(q_a[c].size()), 0);
    for (int c = 0; c < 4; c++) check($sformatf("b%0d_queue_empty", c), 32'(q_b[c].size()), 0);

    // mid-operation reset with queued events and a set overflow
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin pulse_a[0] = 1'b1; accept(0, 0); end
      else pulse_a[0] = 1'b0;
      pulse_b[1] = 1'b0;
      if (k < 4) accept(1, 1);
      step();
    end
    pulse_a[0] = 1'b0;
    pulse_b[1] = 1'b1;
    check("pre_rst_busy_a", 32'(busy_a[0]), 1);
    check("pre_rst_ovf_b",  32'(ovf_b[1]),  1);
    reset_n = 1'b0;
    ack_a = '0;
    ack_b = '0;
    #1;
    check("mid_rst_toggle_a", 32'(toggle_a), 0);
    check("mid_rst_busy_a",   32'(busy_a),   0);
    check("mid_rst_toggle_b", 32'(toggle_b), 0);
    check("mid_rst_busy_b",   32'(busy_b),   0);
    check("mid_rst_ovf_b",    32'(ovf_b),    0);
    for (int c = 0; c < 2; c++) q_a[c].delete();
    for (int c = 0; c < 4; c++) q_b[c].delete();
    exp_a = '0;
    exp_b = '0;
    step();
    reset_n = 1'b1;
    f = flips_a[0] + flips_b[1];
    repeat (10) step();
    check("post_rst_no_flips", 32'(flips_a[0] + flips_b[1] - f), 0);
    check("post_rst_toggle_a", 32'(toggle_a), 0);
    check("post_rst_busy_a",   32'(busy_a),   0);
    check("post_rst_busy_b",   32'(busy_b),   0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
